// File: rtl/fsm_lut_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_lut_prog_pkg
// Purpose  : Shared entry-layout helpers for the programmable LUT FSM, so that
//            the RTL, config drivers and benches build frames identically.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_lut_prog_pkg;

  // Default configuration of the block.
  localparam int DEF_N_STATES = 8;
  localparam int DEF_IN_W     = 5;
  localparam int DEF_OUT_W    = 1;
  localparam int DEF_STATE_W  = $clog2(DEF_N_STATES);

  // Bits in one table entry: {match, next_hit, next_miss, out}.
  function automatic int entry_w(input int in_w, input int state_w, input int out_w);
    return in_w + 2 * state_w + out_w;
  endfunction

  // Length of a complete configuration frame.
  function automatic int cfg_w(input int n_states, input int in_w, input int state_w,
                               input int out_w);
    return n_states * entry_w(in_w, state_w, out_w);
  endfunction

  // Field offsets inside one entry, LSB first.
  function automatic int out_lsb();
    return 0;
  endfunction

  function automatic int miss_lsb(input int out_w);
    return out_w;
  endfunction

  function automatic int hit_lsb(input int state_w, input int out_w);
    return out_w + state_w;
  endfunction

  function automatic int match_lsb(input int state_w, input int out_w);
    return out_w + 2 * state_w;
  endfunction

  // Offsets for the default configuration.
  localparam int OUT_LSB   = out_lsb();
  localparam int MISS_LSB  = miss_lsb(DEF_OUT_W);
  localparam int HIT_LSB   = hit_lsb(DEF_STATE_W, DEF_OUT_W);
  localparam int MATCH_LSB = match_lsb(DEF_STATE_W, DEF_OUT_W);

endpackage
`default_nettype wire

// File: rtl/fsm_lut_prog_cfg_sipo.sv
`default_nettype none
// ============================================================================
// Module   : cfg_sipo_frame
// Purpose  : Serial config receiver: shift register, bit counter, frame-valid
//            flag and daisy-chain output.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_sipo_frame #(
  parameter int CFG_W = 80
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_en,
  input  logic             cfg_din,
  output logic             cfg_dout,
  output logic             cfg_valid,
  output logic [CFG_W-1:0] frame
);

  localparam int CNT_W = $clog2(CFG_W + 1);

  logic [CFG_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  // Shift in accepted bits; a bit arriving on a valid frame restarts framing.
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (cfg_en) begin
      sr_d = {sr_q[CFG_W-2:0], cfg_din};
      if (valid_q) begin
        valid_d = 1'b0;
        cnt_d   = CNT_W'(1);
      end else if (cnt_q == CNT_W'(CFG_W - 1)) begin
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Config state registers, cleared asynchronously so a reset discards a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign cfg_dout  = sr_q[CFG_W-1];
  assign cfg_valid = valid_q;
  assign frame     = sr_q;

endmodule
`default_nettype wire

// File: rtl/fsm_lut_prog.sv
`default_nettype none
// ============================================================================
// Module   : fsm_lut_prog
// Purpose  : Lookup-table Moore FSM whose transition table is loaded over a
//            serial config pin; runs once a complete frame is present.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_lut_prog
  import fsm_lut_prog_pkg::*;
#(
  parameter  int N_STATES = 8,
  parameter  int IN_W     = 5,
  parameter  int OUT_W    = 1,
  localparam int STATE_W  = $clog2(N_STATES),
  localparam int ENTRY_W  = entry_w(IN_W, STATE_W, OUT_W),
  localparam int CFG_W    = cfg_w(N_STATES, IN_W, STATE_W, OUT_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_en,
  input  logic               cfg_din,
  output logic               cfg_dout,
  output logic               cfg_valid,
  input  logic               run,
  input  logic [IN_W-1:0]    in,
  output logic [STATE_W-1:0] state,
  output logic [OUT_W-1:0]   out,
  output logic               err
);

  localparam int MATCH_OFS = match_lsb(STATE_W, OUT_W);
  localparam int HIT_OFS   = hit_lsb(STATE_W, OUT_W);
  localparam int MISS_OFS  = miss_lsb(OUT_W);
  localparam int OUT_OFS   = out_lsb();
  // Tables are padded to a power of two so any state code indexes safely.
  localparam int N_SLOTS   = 1 << STATE_W;

  logic [CFG_W-1:0]   frame;
  logic [IN_W-1:0]    match_tbl [N_SLOTS];
  logic [STATE_W-1:0] hit_tbl   [N_SLOTS];
  logic [STATE_W-1:0] miss_tbl  [N_SLOTS];
  logic [OUT_W-1:0]   out_tbl   [N_SLOTS];

  logic [STATE_W-1:0] state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               err_q, err_d;
  logic               hit;
  logic [STATE_W-1:0] nxt;

  cfg_sipo_frame #(
    .CFG_W(CFG_W)
  ) u_cfg (
    .clk      (clk),
    .reset    (reset),
    .cfg_en   (cfg_en),
    .cfg_din  (cfg_din),
    .cfg_dout (cfg_dout),
    .cfg_valid(cfg_valid),
    .frame    (frame)
  );

  // Unpack the frame into per-state fields; unused slots read as zero.
  for (genvar k = 0; k < N_SLOTS; k++) begin : g_entry
    if (k < N_STATES) begin : g_used
      assign match_tbl[k] = frame[k*ENTRY_W + MATCH_OFS +: IN_W];
      assign hit_tbl[k]   = frame[k*ENTRY_W + HIT_OFS   +: STATE_W];
      assign miss_tbl[k]  = frame[k*ENTRY_W + MISS_OFS  +: STATE_W];
      assign out_tbl[k]   = frame[k*ENTRY_W + OUT_OFS   +: OUT_W];
    end else begin : g_pad
      assign match_tbl[k] = '0;
      assign hit_tbl[k]   = '0;
      assign miss_tbl[k]  = '0;
      assign out_tbl[k]   = '0;
    end
  end

  // Next state and Moore output; config activity forces the FSM to state 0.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = 1'b0;
    hit     = (in == match_tbl[state_q]);
    nxt     = hit ? hit_tbl[state_q] : miss_tbl[state_q];
    if (!cfg_valid || cfg_en) begin
      state_d = '0;
      out_d   = '0;
    end else if (run) begin
      if (int'(nxt) >= N_STATES) begin
        state_d = '0;
        err_d   = 1'b1;
      end else begin
        state_d = nxt;
      end
      out_d = out_tbl[state_d];
    end
  end

  // FSM registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign state = state_q;
  assign out   = out_q;
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_lut_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_lut_prog
// Purpose  : Directed self-checking bench for fsm_lut_prog (4-state and
//            3-state instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_lut_prog;
  import fsm_lut_prog_pkg::*;

  localparam int CW_A = 40;
  localparam int CW_B = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  // Instance A: 4 states
  logic       cfg_en_a, cfg_din_a, cfg_dout_a, cfg_valid_a, run_a, err_a;
  logic [4:0] in_a;
  logic [1:0] state_a;
  logic [0:0] out_a;
  // Instance B: 3 states
  logic       cfg_en_b, cfg_din_b, cfg_dout_b, cfg_valid_b, run_b, err_b;
  logic [4:0] in_b;
  logic [1:0] state_b;
  logic [0:0] out_b;

  fsm_lut_prog #(.N_STATES(4), .IN_W(5), .OUT_W(1)) dut_a (
    .clk(clk), .reset(reset), .cfg_en(cfg_en_a), .cfg_din(cfg_din_a),
    .cfg_dout(cfg_dout_a), .cfg_valid(cfg_valid_a), .run(run_a), .in(in_a),
    .state(state_a), .out(out_a), .err(err_a)
  );

  fsm_lut_prog #(.N_STATES(3), .IN_W(5), .OUT_W(1)) dut_b (
    .clk(clk), .reset(reset), .cfg_en(cfg_en_b), .cfg_din(cfg_din_b),
    .cfg_dout(cfg_dout_b), .cfg_valid(cfg_valid_b), .run(run_b), .in(in_b),
    .state(state_b), .out(out_b), .err(err_b)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [CW_A-1:0] frame_a, exp_sr_a;
  logic [CW_B-1:0] frame_b;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ent(input logic [4:0] m, input logic [1:0] h,
                                     input logic [1:0] mi, input logic o);
    return {m, h, mi, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send frame bits f[hi] down to f[lo] into instance A, tracking the shift register.
  task automatic send_a(input logic [CW_A-1:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      cfg_en_a  = 1'b1;
      cfg_din_a = f[i];
      exp_sr_a  = {exp_sr_a[CW_A-2:0], f[i]};
      tick();
    end
    cfg_en_a = 1'b0;
  endtask

  task automatic send_b(input logic [CW_B-1:0] f);
    for (int i = CW_B - 1; i >= 0; i--) begin
      cfg_en_b  = 1'b1;
      cfg_din_b = f[i];
      tick();
    end
    cfg_en_b = 1'b0;
  endtask

  // Run instance A for one clock with the given input, then check state/out.
  task automatic step_a(input string tag, input logic r, input logic [4:0] v,
                        input logic [1:0] es, input logic eo);
    run_a = r;
    in_a  = v;
    tick();
    check_eq({tag, ".state"}, state_a, es);
    check_eq({tag, ".out"}, out_a, eo);
  endtask

  task automatic step_b(input string tag, input logic [4:0] v, input logic [1:0] es,
                        input logic eo, input logic ee);
    run_b = 1'b1;
    in_b  = v;
    tick();
    check_eq({tag, ".state"}, state_b, es);
    check_eq({tag, ".out"}, out_b, eo);
    check_eq({tag, ".err"}, err_b, ee);
  endtask

  initial begin
    frame_a = {ent(5'h00, 2'd0, 2'd3, 1'b1), ent(5'h1F, 2'd3, 2'd2, 1'b0),
               ent(5'h07, 2'd2, 2'd0, 1'b1), ent(5'h03, 2'd1, 2'd0, 1'b0)};
    frame_b = {ent(5'h00, 2'd0, 2'd0, 1'b0), ent(5'h0A, 2'd3, 2'd2, 1'b0),
               ent(5'h03, 2'd3, 2'd1, 1'b1)};
    exp_sr_a = '0;
    reset = 1'b1;
    cfg_en_a = 1'b0; cfg_din_a = 1'b0; run_a = 1'b0; in_a = '0;
    cfg_en_b = 1'b0; cfg_din_b = 1'b0; run_b = 1'b0; in_b = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check_eq("rst.valid", cfg_valid_a, 1'b0);
    check_eq("rst.state", state_a, 2'd0);
    check_eq("rst.out", out_a, 1'b0);
    check_eq("rst.err", err_a, 1'b0);
    check_eq("rst.dout", cfg_dout_a, 1'b0);

    // Partial frame: 39 bits with run active must not start the FSM
    run_a = 1'b1;
    in_a  = 5'h03;
    send_a(frame_a, CW_A - 1, 1);
    check_eq("part.valid", cfg_valid_a, 1'b0);
    check_eq("part.state", state_a, 2'd0);
    run_a = 1'b0;
    send_a(frame_a, 0, 0);
    check_eq("load.valid", cfg_valid_a, 1'b1);
    check_eq("load.state", state_a, 2'd0);
    check_eq("load.dout", cfg_dout_a, frame_a[CW_A-1]);

    // Hit path around the ring
    step_a("hit0", 1'b1, 5'h03, 2'd1, 1'b1);
    step_a("hit1", 1'b1, 5'h07, 2'd2, 1'b0);
    step_a("hit2", 1'b1, 5'h1F, 2'd3, 1'b1);
    step_a("hit3", 1'b1, 5'h00, 2'd0, 1'b0);

    // Miss path and hold
    step_a("miss0", 1'b1, 5'h03, 2'd1, 1'b1);
    step_a("miss1", 1'b1, 5'h09, 2'd0, 1'b0);
    step_a("hold0", 1'b0, 5'h07, 2'd0, 1'b0);
    step_a("miss2", 1'b1, 5'h03, 2'd1, 1'b1);
    step_a("hold1", 1'b0, 5'h09, 2'd1, 1'b1);
    check_eq("hold.err", err_a, 1'b0);

    // Asynchronous reset in the middle of a cycle
    run_a = 1'b1;
    in_a  = 5'h07;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("arst.state", state_a, 2'd0);
    check_eq("arst.out", out_a, 1'b0);
    check_eq("arst.valid", cfg_valid_a, 1'b0);
    check_eq("arst.dout", cfg_dout_a, 1'b0);
    exp_sr_a = '0;
    run_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Reload, then reconfigure while running
    send_a(frame_a, CW_A - 1, 0);
    check_eq("reload.valid", cfg_valid_a, 1'b1);
    step_a("rc.pre", 1'b1, 5'h03, 2'd1, 1'b1);
    run_a = 1'b1;
    in_a  = 5'h07;
    send_a(41'h1, 0, 0);
    check_eq("rc.valid", cfg_valid_a, 1'b0);
    check_eq("rc.state", state_a, 2'd0);
    check_eq("rc.out", out_a, 1'b0);
    check_eq("rc.dout", cfg_dout_a, exp_sr_a[CW_A-1]);
    check_eq("rc.dout_bit", cfg_dout_a, frame_a[CW_A-2]);
    step_a("rc.after", 1'b1, 5'h03, 2'd0, 1'b0);

    // Out-of-range next state on the 3-state instance
    send_b(frame_b);
    check_eq("b.valid", cfg_valid_b, 1'b1);
    step_b("b0", 5'h00, 2'd1, 1'b0, 1'b0);
    step_b("b1", 5'h0A, 2'd0, 1'b1, 1'b1);
    step_b("b2", 5'h1F, 2'd1, 1'b0, 1'b0);
    step_b("b3", 5'h1F, 2'd2, 1'b0, 1'b0);
    step_b("b4", 5'h00, 2'd0, 1'b1, 1'b0);
    step_b("b5", 5'h03, 2'd0, 1'b1, 1'b1);
    step_b("b6", 5'h00, 2'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
